// File: rtl/saes32_masked_column_seq_if.sv
// Request, FU-issue and response buses of the masked saes32 column sequencer.
// master = sequencer side, slave = front end / FU / consumer side.
interface saes32_masked_column_seq_if;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic        req_decrypt;
    logic        req_middle;
    logic [31:0] req_key;
    logic [31:0] req_share_a;
    logic [31:0] req_share_b;
    logic        fu_valid;
    logic [31:0] fu_rs1;
    logic [31:0] fu_rs2;
    logic [31:0] fu_rs3;
    logic [1:0]  fu_bs;
    logic        fu_op_encs;
    logic        fu_op_encsm;
    logic        fu_op_decs;
    logic        fu_op_decsm;
    logic [31:0] fu_rd;
    logic        fu_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_error;

    modport master (
        input  flush, req_valid, req_decrypt, req_middle, req_key, req_share_a, req_share_b,
        output req_ready,
        output fu_valid, fu_rs1, fu_rs2, fu_rs3, fu_bs,
        output fu_op_encs, fu_op_encsm, fu_op_decs, fu_op_decsm,
        input  fu_rd, fu_ready,
        output rsp_valid, rsp_data, rsp_error,
        input  rsp_ready
    );

    modport slave (
        output flush, req_valid, req_decrypt, req_middle, req_key, req_share_a, req_share_b,
        input  req_ready,
        input  fu_valid, fu_rs1, fu_rs2, fu_rs3, fu_bs,
        input  fu_op_encs, fu_op_encsm, fu_op_decs, fu_op_decsm,
        output fu_rd, fu_ready,
        input  rsp_valid, rsp_data, rsp_error,
        output rsp_ready
    );
endinterface

// File: rtl/saes32_masked_column_seq.sv
// Drives four chained masked saes32 FU ops (bs = 0..3) over one AES column and
// returns the accumulated word; handles FU timeout, flush and disabled decrypt.
module saes32_masked_column_seq #(
    parameter bit          SAES_DEC_EN = 1'b1,
    parameter int unsigned TIMEOUT     = 16
) (
    input logic                        clk,
    input logic                        reset,
    saes32_masked_column_seq_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] acc_q, acc_d, sa_q, sa_d, sb_q, sb_d, rsp_data_q, rsp_data_d;
    logic [3:0]  mode_q, mode_d, op_q, op_d;
    logic [1:0]  bs_q, bs_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        fu_valid_q, fu_valid_d, rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
    logic        accept, dec_blocked, last_op, timed_out;

    assign bus.req_ready = (state_q == IDLE) && !bus.flush;
    assign accept        = bus.req_ready && bus.req_valid;
    assign dec_blocked   = bus.req_decrypt && !SAES_DEC_EN;
    assign last_op       = bus.fu_ready && (bs_q == 2'd3);
    assign timed_out     = !bus.fu_ready && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // flush wins over every other event in every state
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = dec_blocked ? RESP : ISSUE;
                ISSUE:   if (last_op || timed_out) state_d = RESP;
                RESP:    if (bus.rsp_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        acc_d       = acc_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        mode_d      = mode_q;
        bs_d        = bs_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        if (!bus.flush) begin
            case (state_q)
                IDLE: if (accept) begin
                    acc_d  = bus.req_key;
                    sa_d   = bus.req_share_a;
                    sb_d   = bus.req_share_b;
                    mode_d = {!bus.req_decrypt && !bus.req_middle, !bus.req_decrypt && bus.req_middle,
                              bus.req_decrypt && !bus.req_middle, bus.req_decrypt && bus.req_middle};
                    bs_d   = 2'd0;
                    cnt_d  = 8'd0;
                    if (dec_blocked) begin
                        rsp_data_d  = 32'd0;
                        rsp_error_d = 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus.fu_ready) begin
                        acc_d = bus.fu_rd;
                        cnt_d = 8'd0;
                        if (bs_q == 2'd3) begin
                            rsp_data_d  = bus.fu_rd;
                            rsp_error_d = 1'b0;
                        end else begin
                            bs_d = bs_q + 2'd1;
                        end
                    end else if (timed_out) begin
                        rsp_data_d  = acc_q;
                        rsp_error_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
        fu_valid_d  = (state_d == ISSUE);
        rsp_valid_d = (state_d == RESP);
        op_d        = fu_valid_d ? mode_d : 4'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            sa_q        <= '0;
            sb_q        <= '0;
            mode_q      <= '0;
            op_q        <= '0;
            bs_q        <= '0;
            cnt_q       <= '0;
            fu_valid_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            mode_q      <= mode_d;
            op_q        <= op_d;
            bs_q        <= bs_d;
            cnt_q       <= cnt_d;
            fu_valid_q  <= fu_valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign bus.fu_valid    = fu_valid_q;
    assign bus.fu_rs1      = acc_q;
    assign bus.fu_rs2      = sa_q;
    assign bus.fu_rs3      = sb_q;
    assign bus.fu_bs       = bs_q;
    assign bus.fu_op_encs  = op_q[3];
    assign bus.fu_op_encsm = op_q[2];
    assign bus.fu_op_decs  = op_q[1];
    assign bus.fu_op_decsm = op_q[0];
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_error   = rsp_error_q;
endmodule

// File: tb/tb_saes32_masked_column_seq.sv
// Bench for the column sequencer: dut 0 (decrypt on, TIMEOUT 16) and dut 1
// (decrypt off, TIMEOUT 4), each with a delay-programmable FU model.
module tb_saes32_masked_column_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    saes32_masked_column_seq_if bus[2] ();

    saes32_masked_column_seq #(.SAES_DEC_EN(1'b1), .TIMEOUT(16)) u_dut0 (.clk(clk), .reset(reset), .bus(bus[0]));
    saes32_masked_column_seq #(.SAES_DEC_EN(1'b0), .TIMEOUT(4))  u_dut1 (.clk(clk), .reset(reset), .bus(bus[1]));

    logic        flush_i[2], req_valid[2], req_dec[2], req_mid[2], rsp_rdy[2];
    logic [31:0] req_key[2], req_a[2], req_b[2];
    logic        fu_rdy[2];
    logic [31:0] fu_rd[2];
    logic        req_rdy_o[2], fu_vld_o[2], rsp_vld_o[2], rsp_err_o[2];
    logic [31:0] fu_rs1_o[2], fu_rs2_o[2], fu_rs3_o[2], rsp_data_o[2];
    logic [1:0]  fu_bs_o[2];
    logic [3:0]  fu_op_o[2];

    for (genvar g = 0; g < 2; g++) begin : g_bus
        assign bus[g].flush       = flush_i[g];
        assign bus[g].req_valid   = req_valid[g];
        assign bus[g].req_decrypt = req_dec[g];
        assign bus[g].req_middle  = req_mid[g];
        assign bus[g].req_key     = req_key[g];
        assign bus[g].req_share_a = req_a[g];
        assign bus[g].req_share_b = req_b[g];
        assign bus[g].fu_rd       = fu_rd[g];
        assign bus[g].fu_ready    = fu_rdy[g];
        assign bus[g].rsp_ready   = rsp_rdy[g];
        assign req_rdy_o[g]  = bus[g].req_ready;
        assign fu_vld_o[g]   = bus[g].fu_valid;
        assign fu_rs1_o[g]   = bus[g].fu_rs1;
        assign fu_rs2_o[g]   = bus[g].fu_rs2;
        assign fu_rs3_o[g]   = bus[g].fu_rs3;
        assign fu_bs_o[g]    = bus[g].fu_bs;
        assign fu_op_o[g]    = {bus[g].fu_op_encs, bus[g].fu_op_encsm, bus[g].fu_op_decs, bus[g].fu_op_decsm};
        assign rsp_vld_o[g]  = bus[g].rsp_valid;
        assign rsp_data_o[g] = bus[g].rsp_data;
        assign rsp_err_o[g]  = bus[g].rsp_error;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        else n_pass++;
    endtask

    // stand-in FU transfer: depends on every operand so miswired shares show up
    function automatic logic [31:0] fu_fn(input logic [31:0] rs1, rs2, rs3, input logic [1:0] bs);
        int sh;
        sh = 8 * int'(bs);
        return rs1 ^ (32'h1 << sh) ^ ((rs2 << sh) | (rs2 >> (32 - sh))) ^ (rs3 >> bs);
    endfunction

    // column result: chain four ops; an op needing >= TIMEOUT cycles aborts with acc so far
    function automatic void ref_col(input bit dec_ok, input logic [31:0] key, a, b, input logic [31:0] dly,
                                    input int to, output logic [31:0] d, output logic e, output int nv);
        d = 32'd0; e = 1'b1; nv = 0;
        if (!dec_ok) return;
        d = key; e = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (int'(dly[8*k +: 8]) >= to) begin
                e = 1'b1; nv += to;
                return;
            end
            nv += int'(dly[8*k +: 8]) + 1;
            d = fu_fn(d, a, b, 2'(k));
        end
    endfunction

    // FU model: ready after fu_dly cycles per op, checks operand stability and op select
    logic [31:0] fu_dly[2];
    logic        fu_force[2];
    logic [3:0]  exp_op[2];
    int          fu_wait[2], fu_opn[2];
    logic [31:0] cap_rs1[2], cap_rs2[2], cap_rs3[2];
    logic [3:0]  cap_op[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (fu_force[i]) begin
                fu_rdy[i] = 1'b1; fu_rd[i] = $urandom; fu_wait[i] = 0;
            end else if (reset || !fu_vld_o[i]) begin
                fu_rdy[i] = 1'b0; fu_wait[i] = 0; fu_opn[i] = 0;
                if (!reset) chk("op_idle", 32'(fu_op_o[i]), 32'd0);
            end else begin
                if (fu_wait[i] == 0) begin
                    cap_rs1[i] = fu_rs1_o[i]; cap_rs2[i] = fu_rs2_o[i];
                    cap_rs3[i] = fu_rs3_o[i]; cap_op[i] = fu_op_o[i];
                    chk("bs_seq", 32'(fu_bs_o[i]), 32'(fu_opn[i]));
                    chk("op_sel", 32'(fu_op_o[i]), 32'(exp_op[i]));
                end else begin
                    chk("rs1_hold", fu_rs1_o[i], cap_rs1[i]);
                    chk("rs2_hold", fu_rs2_o[i], cap_rs2[i]);
                    chk("rs3_hold", fu_rs3_o[i], cap_rs3[i]);
                    chk("op_hold", 32'(fu_op_o[i]), 32'(cap_op[i]));
                end
                if (fu_wait[i] >= int'(fu_dly[i][8*int'(fu_bs_o[i]) +: 8])) begin
                    fu_rdy[i] = 1'b1;
                    fu_rd[i]  = fu_fn(fu_rs1_o[i], fu_rs2_o[i], fu_rs3_o[i], fu_bs_o[i]);
                    fu_wait[i] = 0; fu_opn[i]++;
                end else begin
                    fu_rdy[i] = 1'b0; fu_wait[i]++;
                end
            end
        end
    end

    task automatic chk_reset_vals(input int i);
        chk("rst_fu_vld", 32'(fu_vld_o[i]), 32'd0);
        chk("rst_rs1", fu_rs1_o[i], 32'd0);
        chk("rst_rs2", fu_rs2_o[i], 32'd0);
        chk("rst_rs3", fu_rs3_o[i], 32'd0);
        chk("rst_bs", 32'(fu_bs_o[i]), 32'd0);
        chk("rst_op", 32'(fu_op_o[i]), 32'd0);
        chk("rst_rsp_vld", 32'(rsp_vld_o[i]), 32'd0);
        chk("rst_rsp_data", rsp_data_o[i], 32'd0);
        chk("rst_rsp_err", 32'(rsp_err_o[i]), 32'd0);
        chk("rst_req_rdy", 32'(req_rdy_o[i]), 32'd1);
    endtask

    task automatic send(input int i, input bit dec, input bit mid, input logic [31:0] key, a, b);
        int n = 0;
        req_dec[i] = dec; req_mid[i] = mid; req_key[i] = key; req_a[i] = a; req_b[i] = b;
        exp_op[i] = dec ? (mid ? 4'b0001 : 4'b0010) : (mid ? 4'b0100 : 4'b1000);
        req_valid[i] = 1'b1;
        while (!req_rdy_o[i] && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("req_wait", 32'(req_rdy_o[i]), 32'd1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int i, output logic [31:0] d, output logic e, output int lat, output int nv);
        lat = 0; nv = 0;
        do begin
            @(negedge clk); lat++;
            if (fu_vld_o[i]) nv++;
        end while (!rsp_vld_o[i] && lat < 300);
        chk("rsp_seen", 32'(rsp_vld_o[i]), 32'd1);
        d = rsp_data_o[i]; e = rsp_err_o[i];
    endtask

    task automatic run(input int i, input bit dec, input bit mid, input logic [31:0] key, a, b,
                       input logic [31:0] dly, input int stall, output logic [31:0] d);
        logic [31:0] ed, gd;
        logic ee, ge;
        int en, lat, nv;
        fu_dly[i] = dly;
        ref_col((i == 0) || !dec, key, a, b, dly, (i == 0) ? 16 : 4, ed, ee, en);
        rsp_rdy[i] = (stall == 0);
        send(i, dec, mid, key, a, b);
        wait_rsp(i, gd, ge, lat, nv);
        chk("rsp_data", gd, ed);
        chk("rsp_err", 32'(ge), 32'(ee));
        chk("fu_cycles", 32'(nv), 32'(en));
        chk("rsp_lat", 32'(lat), 32'(en + 1));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_vld", 32'(rsp_vld_o[i]), 32'd1);
            chk("stall_data", rsp_data_o[i], ed);
            chk("stall_err", 32'(rsp_err_o[i]), 32'(ee));
        end
        rsp_rdy[i] = 1'b1;
        @(negedge clk);
        chk("rsp_drop", 32'(rsp_vld_o[i]), 32'd0);
        chk("idle_rdy", 32'(req_rdy_o[i]), 32'd1);
        d = gd;
    endtask

    initial begin
        logic [31:0] d;
        int n;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            flush_i[i] = 1'b0; req_valid[i] = 1'b0; req_dec[i] = 1'b0; req_mid[i] = 1'b0;
            req_key[i] = '0; req_a[i] = '0; req_b[i] = '0; rsp_rdy[i] = 1'b1;
            fu_dly[i] = '0; fu_force[i] = 1'b0; exp_op[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk_reset_vals(0);
        chk_reset_vals(1);
        reset = 1'b0;
        @(negedge clk);

        // encrypt final, FU always ready: T+5 response
        run(0, 1'b0, 1'b0, 32'h10000000, 32'd0, 32'd0, 32'h00000000, 0, d);
        chk("enc_const", d, 32'h11010101);
        // decrypt middle, each op held 3 cycles
        run(0, 1'b1, 1'b1, 32'hA5A5A5A5, 32'd0, 32'd0, 32'h02020202, 0, d);
        chk("decsm_const", d, 32'hA4A4A4A4);
        // FU never ready on the TIMEOUT=4 unit
        run(1, 1'b0, 1'b0, 32'h12345678, 32'd0, 32'd0, 32'hFFFFFFFF, 0, d);
        chk("timeout_const", d, 32'h12345678);
        // decrypt disabled, then a normal encrypt
        run(1, 1'b1, 1'b0, $urandom, $urandom, $urandom, 32'h00000000, 0, d);
        chk("dec_off_const", d, 32'd0);
        run(1, 1'b0, 1'b1, $urandom, $urandom, $urandom, 32'h01020001, 0, d);
        // timeout boundaries: last allowed cycle, first disallowed, mid-column abort
        run(1, 1'b0, 1'b0, $urandom, $urandom, $urandom, 32'h03030303, 0, d);
        run(1, 1'b0, 1'b1, $urandom, $urandom, $urandom, 32'h04000000, 0, d);
        run(1, 1'b0, 1'b0, $urandom, $urandom, $urandom, 32'hFFFFFF00, 0, d);

        // flush coincident with fu_ready at bs = 2
        fu_dly[0] = 32'h00010000;
        send(0, 1'b0, 1'b0, $urandom, $urandom, $urandom);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!(fu_bs_o[0] == 2'd2 && fu_rdy[0]) && n < 40);
        chk("flush_at_bs2", 32'(fu_bs_o[0]), 32'd2);
        flush_i[0] = 1'b1;
        @(posedge clk); #1;
        flush_i[0] = 1'b0;
        @(negedge clk);
        chk("flush_fu_vld", 32'(fu_vld_o[0]), 32'd0);
        chk("flush_rsp_vld", 32'(rsp_vld_o[0]), 32'd0);
        chk("flush_req_rdy", 32'(req_rdy_o[0]), 32'd1);
        fu_force[0] = 1'b1;
        repeat (3) begin @(negedge clk); chk("late_rdy_vld", 32'(fu_vld_o[0]), 32'd0); end
        fu_force[0] = 1'b0;
        repeat (6) begin @(negedge clk); chk("flush_no_rsp", 32'(rsp_vld_o[0]), 32'd0); end
        // flush beats a simultaneous request
        req_key[0] = $urandom; req_valid[0] = 1'b1; flush_i[0] = 1'b1;
        #1 chk("flush_rdy", 32'(req_rdy_o[0]), 32'd0);
        @(posedge clk); #1;
        flush_i[0] = 1'b0; req_valid[0] = 1'b0;
        @(negedge clk);
        chk("flush_no_accept", 32'(fu_vld_o[0]), 32'd0);
        run(0, 1'b0, 1'b1, $urandom, $urandom, $urandom, 32'h01000200, 0, d);

        // response stalled for 5 cycles
        run(0, 1'b1, 1'b0, $urandom, $urandom, $urandom, 32'h00010203, 5, d);

        for (int k = 0; k < 30; k++) begin
            int i = k % 2;
            int m = (i == 0) ? 3 : 4;
            logic [31:0] dly;
            dly = {8'($urandom_range(0, m)), 8'($urandom_range(0, m)), 8'($urandom_range(0, m)), 8'($urandom_range(0, m))};
            run(i, 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, dly, (k % 7 == 3) ? 2 : 0, d);
        end

        // reset mid-ISSUE acts immediately
        fu_dly[0] = 32'h03030303;
        send(0, 1'b0, 1'b0, $urandom, $urandom, $urandom);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk_reset_vals(0);
        chk_reset_vals(1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run(0, 1'b1, 1'b1, $urandom, $urandom, $urandom, 32'h00000100, 0, d);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/saes32_masked_column_seq.md
Name: saes32_masked_column_seq

Overview:
- Issue-side sequencer that drives the masked saes32 functional unit (FU) to process one full 32-bit AES column.
- Accepts a column as two Boolean shares plus a 32-bit round-key word.
- Issues four FU operations (bs = 0..3), chaining each FU rd back as the next rs1, and returns the accumulated word.
- Sits between the crypto instruction decode / microcode front end and the FU; owns the FU valid/ready handshake, timeout and flush.

Parameters:
- SAES_DEC_EN, 1: decrypt ops permitted; when 0, decrypt requests are answered with an error response.
- TIMEOUT, 16: maximum cycles one FU op may wait for fu_ready before abort; range 2..255.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  abandon current operation, no response
- req_valid  in  1  request present
- req_ready  out  1  sequencer accepts request
- req_decrypt  in  1  1 = decs/decsm, 0 = encs/encsm
- req_middle  in  1  1 = middle round (…sm op), 0 = final round
- req_key  in  32  round-key word, initial rs1
- req_share_a  in  32  column share A (to FU rs2)
- req_share_b  in  32  column share B (to FU rs3)
- fu_valid  out  1  FU op request
- fu_rs1  out  32  accumulator
- fu_rs2  out  32  latched share A
- fu_rs3  out  32  latched share B
- fu_bs  out  2  byte select
- fu_op_encs, fu_op_encsm, fu_op_decs, fu_op_decsm  out  1 each  one-hot op select, all 0 when fu_valid = 0
- fu_rd  in  32  FU result
- fu_ready  in  1  FU result valid this cycle
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  final accumulator
- rsp_error  out  1  1 = timeout or disabled decrypt

Behaviour:
- States: IDLE, ISSUE, RESP. Reset (asynchronous) or flush forces IDLE.
- Reset values: fu_valid = 0, all op selects = 0, fu_bs = 0, fu_rs1/rs2/rs3 = 0, rsp_valid = 0, rsp_data = 0, rsp_error = 0. req_ready = 1 after reset, because it is a combinational decode of the state.
- All outputs except req_ready are registered.

IDLE:
- req_ready = (state == IDLE) && !flush.
- On req_valid && req_ready, latch key into acc, latch shares, op and mode; set bs = 0 and the timeout count = 0.
- If req_decrypt && !SAES_DEC_EN: go to RESP with rsp_error = 1 and rsp_data = 0.
- Otherwise go to ISSUE.

ISSUE:
- fu_valid = 1. fu_rs1 = acc, fu_rs2/fu_rs3 = latched shares, fu_bs = bs, exactly one op select high.
- All FU-facing signals are held stable until the fu_ready cycle.
- On fu_ready: acc <= fu_rd.
  - If bs == 3: go to RESP with rsp_data = fu_rd and rsp_error = 0; fu_valid drops next cycle.
  - Else: bs <= bs + 1 and fu_rs1 <= fu_rd. fu_valid stays high, which is a back-to-back issue with no bubble. Timeout count clears.
- fu_ready while fu_valid = 0 is ignored.
- Timeout: the count increments on each ISSUE cycle without fu_ready. When it reaches TIMEOUT-1 without fu_ready, go to RESP with rsp_error = 1 and rsp_data = current acc; fu_valid drops.
- Latency: with fu_ready tied high, a request accepted on edge T gives fu_valid high for T+1..T+4 and rsp_valid at T+5.

RESP:
- rsp_valid = 1; data and error are held until rsp_ready.
- On rsp_ready, go to IDLE. A new request can be accepted the cycle after.

flush:
- Has priority over every event, including a simultaneous fu_ready, rsp_ready or req_valid.
- Next cycle: IDLE, fu_valid = 0, rsp_valid = 0, no response ever delivered.
- A late fu_ready arriving after the flush is ignored.

Other rules:
- bs wraps only by returning to IDLE; it is never incremented past 3.
- The sequencer performs no byte arithmetic: acc is replaced, not XORed.

Test Plan:
- Encrypt final round with the bench FU model rd = rs1 ^ (32'h1 << 8*bs), fu_ready tied 1, key 0x10000000 -> fu_bs sequence 0,1,2,3 with fu_op_encs only; rsp_valid at T+5; rsp_data 0x11010101; rsp_error 0.
- Decrypt middle round with the FU model asserting fu_ready 2 cycles after each op, key 0xA5A5A5A5 -> fu_op_decsm only; each op held 3 cycles with stable rs1/rs2/rs3; rsp_data 0xA4A4A4A4 after 12 ISSUE cycles.
- FU never ready, TIMEOUT = 4, key 0x12345678 -> fu_valid for exactly 4 cycles; rsp_error 1; rsp_data 0x12345678.
- SAES_DEC_EN = 0 with a decrypt request -> fu_valid never asserts; rsp_valid next cycle with rsp_error 1 and rsp_data 0; an encrypt request afterwards completes normally.
- flush asserted in ISSUE at bs = 2, coincident with fu_ready -> no rsp_valid; IDLE with req_ready 1 the next cycle; a following request returns the correct result.
- rsp_ready held 0 for 5 cycles, and reset asserted mid-ISSUE -> rsp_data/rsp_error stable while stalled; reset immediately clears fu_valid and rsp_valid and all outputs take their reset values.
